// File: rtl/seq_ctrl_unit.sv
// Microcoded-style sequencer: fetch/decode/exec/writeback FSM with PC, call stack and
// registered datapath strobes. en=0 freezes everything (program-load mode).
module seq_ctrl_unit #(
    parameter int unsigned PC_W        = 5,
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 en,
    input  logic [INSTR_W-1:0]                   instr_i,
    input  logic                                 instr_valid_i,
    input  logic                                 exec_done_i,
    input  logic                                 zero_i,
    input  logic                                 carry_i,
    output logic [PC_W-1:0]                      pc_o,
    output logic [2:0]                           state_o,
    output logic                                 alu_ce_o,
    output logic                                 acc_we_o,
    output logic                                 rf_we_o,
    output logic                                 dm_we_o,
    output logic [INSTR_W-1:0]                   ir_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     sp_o,
    output logic                                 halted_o,
    output logic                                 stack_err_o
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    localparam logic [3:0] OP_JMP  = 4'd1;
    localparam logic [3:0] OP_CALL = 4'd2;
    localparam logic [3:0] OP_RET  = 4'd3;
    localparam logic [3:0] OP_BRZ  = 4'd4;
    localparam logic [3:0] OP_BRC  = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd6;
    localparam logic [3:0] OP_DP0  = 4'd7;

    state_e                 state_q, state_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [INSTR_W-1:0]     ir_q, ir_d;
    logic [SP_W-1:0]        sp_q, sp_d;
    logic [PC_W-1:0]        stack_q [STACK_DEPTH];
    logic [PC_W-1:0]        stack_d [STACK_DEPTH];
    logic                   taken_q, taken_d;
    logic                   alu_ce_q, alu_ce_d;
    logic                   acc_we_q, acc_we_d;
    logic                   rf_we_q, rf_we_d;
    logic                   dm_we_q, dm_we_d;
    logic                   halted_q, halted_d;
    logic                   stack_err_q, stack_err_d;

    logic [3:0]             opc;
    logic [1:0]             wb_sel;
    logic [PC_W-1:0]        target;
    logic [PC_W-1:0]        pc_inc;
    logic                   is_dp;

    assign opc    = ir_q[INSTR_W-1 -: 4];
    assign wb_sel = ir_q[INSTR_W-7 -: 2];
    assign target = ir_q[PC_W-1:0];
    assign pc_inc = pc_q + PC_W'(1);
    assign is_dp  = (opc >= OP_DP0);

    // Next-state, PC/stack update and next-cycle strobe values
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        sp_d        = sp_q;
        stack_d     = stack_q;
        taken_d     = taken_q;
        alu_ce_d    = 1'b0;
        acc_we_d    = 1'b0;
        rf_we_d     = 1'b0;
        dm_we_d     = 1'b0;
        halted_d    = halted_q;
        stack_err_d = stack_err_q;

        if (en) begin
            case (state_q)
                S_FETCH: begin
                    if (instr_valid_i) begin
                        ir_d    = instr_i;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (opc == OP_HALT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d  = S_EXEC;
                        alu_ce_d = is_dp;
                    end
                end
                S_EXEC: begin
                    taken_d = ((opc == OP_BRZ) && zero_i) || ((opc == OP_BRC) && carry_i);
                    if (!is_dp || exec_done_i) begin
                        state_d = S_WB;
                        if (is_dp) begin
                            case (wb_sel)
                                2'd0:    acc_we_d = 1'b1;
                                2'd1:    rf_we_d  = 1'b1;
                                2'd2:    dm_we_d  = 1'b1;
                                default: ;
                            endcase
                        end
                    end else begin
                        alu_ce_d = 1'b1;
                    end
                end
                S_WB: begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                    case (opc)
                        OP_JMP: pc_d = target;
                        OP_CALL: begin
                            if (sp_q == SP_W'(STACK_DEPTH)) begin
                                pc_d        = pc_q;
                                stack_err_d = 1'b1;
                                halted_d    = 1'b1;
                                state_d     = S_HALT;
                            end else begin
                                stack_d[PTR_W'(sp_q)] = pc_inc;
                                sp_d                  = sp_q + SP_W'(1);
                                pc_d                  = target;
                            end
                        end
                        OP_RET: begin
                            if (sp_q == '0) begin
                                pc_d        = pc_q;
                                stack_err_d = 1'b1;
                                halted_d    = 1'b1;
                                state_d     = S_HALT;
                            end else begin
                                pc_d = stack_q[PTR_W'(sp_q - SP_W'(1))];
                                sp_d = sp_q - SP_W'(1);
                            end
                        end
                        OP_BRZ, OP_BRC: if (taken_q) pc_d = target;
                        default: ;
                    endcase
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            sp_q        <= '0;
            taken_q     <= 1'b0;
            alu_ce_q    <= 1'b0;
            acc_we_q    <= 1'b0;
            rf_we_q     <= 1'b0;
            dm_we_q     <= 1'b0;
            halted_q    <= 1'b0;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            sp_q        <= sp_d;
            taken_q     <= taken_d;
            alu_ce_q    <= alu_ce_d;
            acc_we_q    <= acc_we_d;
            rf_we_q     <= rf_we_d;
            dm_we_q     <= dm_we_d;
            halted_q    <= halted_d;
            stack_err_q <= stack_err_d;
        end
    end

    // Return-address storage carries no reset; only sp_q defines valid entries
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign pc_o        = pc_q;
    assign state_o     = state_q;
    assign ir_o        = ir_q;
    assign sp_o        = sp_q;
    assign alu_ce_o    = alu_ce_q;
    assign acc_we_o    = acc_we_q;
    assign rf_we_o     = rf_we_q;
    assign dm_we_o     = dm_we_q;
    assign halted_o    = halted_q;
    assign stack_err_o = stack_err_q;

endmodule

// File: tb/tb_seq_ctrl_unit.sv
// Directed bench for seq_ctrl_unit with hand-computed expectations (default parameters).
module tb_seq_ctrl_unit;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [15:0] instr_i;
    logic        instr_valid_i;
    logic        exec_done_i;
    logic        zero_i;
    logic        carry_i;
    logic [4:0]  pc_o;
    logic [2:0]  state_o;
    logic        alu_ce_o;
    logic        acc_we_o;
    logic        rf_we_o;
    logic        dm_we_o;
    logic [15:0] ir_o;
    logic [3:0]  sp_o;
    logic        halted_o;
    logic        stack_err_o;

    int vectors;
    int miscompares;

    seq_ctrl_unit #(.PC_W(5), .INSTR_W(16), .STACK_DEPTH(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .instr_i      (instr_i),
        .instr_valid_i(instr_valid_i),
        .exec_done_i  (exec_done_i),
        .zero_i       (zero_i),
        .carry_i      (carry_i),
        .pc_o         (pc_o),
        .state_o      (state_o),
        .alu_ce_o     (alu_ce_o),
        .acc_we_o     (acc_we_o),
        .rf_we_o      (rf_we_o),
        .dm_we_o      (dm_we_o),
        .ir_o         (ir_o),
        .sp_o         (sp_o),
        .halted_o     (halted_o),
        .stack_err_o  (stack_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0; en = 1'b1; instr_i = '0; instr_valid_i = 1'b0;
        exec_done_i = 1'b0; zero_i = 1'b0; carry_i = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic run4(input logic [15:0] ins);
        instr_i = ins; instr_valid_i = 1'b1; exec_done_i = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        apply_reset();
        rstn = 1'b0;
        #1;
        vectors++;
        if ({state_o, pc_o, ir_o, sp_o} !== {3'd0, 5'd0, 16'h0, 4'd0}) begin
            miscompares++;
            $display("FAIL reset_regs: got st=%0d pc=%h ir=%h sp=%0d, want 0/0/0/0", state_o, pc_o, ir_o, sp_o);
        end
        vectors++;
        if ({alu_ce_o, acc_we_o, rf_we_o, dm_we_o, halted_o, stack_err_o} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000000",
                     {alu_ce_o, acc_we_o, rf_we_o, dm_we_o, halted_o, stack_err_o});
        end
        rstn = 1'b1;
        step();
        vectors++;
        if ({state_o, pc_o} !== {3'd0, 5'd0}) begin
            miscompares++;
            $display("FAIL reset_idle: got st=%0d pc=%h want st=0 pc=0", state_o, pc_o);
        end
    endtask

    task automatic test_dp_op();
        apply_reset();
        instr_i = 16'h7005; instr_valid_i = 1'b1; exec_done_i = 1'b1;
        step();
        vectors++;
        if ({state_o, ir_o} !== {3'd1, 16'h7005}) begin
            miscompares++;
            $display("FAIL dp_decode: got st=%0d ir=%h want st=1 ir=7005", state_o, ir_o);
        end
        step();
        vectors++;
        if ({state_o, alu_ce_o, acc_we_o} !== {3'd2, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL dp_exec: got st=%0d alu=%b acc=%b want 2/1/0", state_o, alu_ce_o, acc_we_o);
        end
        step();
        vectors++;
        if ({state_o, alu_ce_o, acc_we_o, rf_we_o, dm_we_o} !== {3'd3, 4'b0100}) begin
            miscompares++;
            $display("FAIL dp_wb: got st=%0d strobes=%b want 3/0100", state_o,
                     {alu_ce_o, acc_we_o, rf_we_o, dm_we_o});
        end
        step();
        vectors++;
        if ({state_o, pc_o, acc_we_o} !== {3'd0, 5'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL dp_done: got st=%0d pc=%h acc=%b want 0/01/0", state_o, pc_o, acc_we_o);
        end
    endtask

    task automatic test_call_ret();
        apply_reset();
        repeat (3) run4(16'h0000);
        vectors++;
        if (pc_o !== 5'd3) begin
            miscompares++;
            $display("FAIL nop_pc: got %h want 03", pc_o);
        end
        run4(16'h2010);
        vectors++;
        if ({pc_o, sp_o} !== {5'h10, 4'd1}) begin
            miscompares++;
            $display("FAIL call: got pc=%h sp=%0d want pc=10 sp=1", pc_o, sp_o);
        end
        run4(16'h3000);
        vectors++;
        if ({pc_o, sp_o, stack_err_o} !== {5'h04, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL ret: got pc=%h sp=%0d err=%b want pc=04 sp=0 err=0", pc_o, sp_o, stack_err_o);
        end
    endtask

    task automatic test_stack_errors();
        apply_reset();
        for (int k = 0; k < 8; k++) run4(16'h2010 + 16'(k));
        vectors++;
        if ({pc_o, sp_o} !== {5'h17, 4'd8}) begin
            miscompares++;
            $display("FAIL call_nest: got pc=%h sp=%0d want pc=17 sp=8", pc_o, sp_o);
        end
        run4(16'h2005);
        vectors++;
        if ({state_o, pc_o, sp_o, halted_o, stack_err_o} !== {3'd4, 5'h17, 4'd8, 2'b11}) begin
            miscompares++;
            $display("FAIL call_overflow: got st=%0d pc=%h sp=%0d h=%b e=%b want 4/17/8/1/1",
                     state_o, pc_o, sp_o, halted_o, stack_err_o);
        end
        apply_reset();
        run4(16'h3000);
        vectors++;
        if ({state_o, pc_o, sp_o, halted_o, stack_err_o} !== {3'd4, 5'h00, 4'd0, 2'b11}) begin
            miscompares++;
            $display("FAIL ret_underflow: got st=%0d pc=%h sp=%0d h=%b e=%b want 4/00/0/1/1",
                     state_o, pc_o, sp_o, halted_o, stack_err_o);
        end
    endtask

    task automatic test_branch();
        apply_reset();
        zero_i = 1'b0;
        run4(16'h4009);
        vectors++;
        if (pc_o !== 5'd1) begin
            miscompares++;
            $display("FAIL brz_not_taken: got pc=%h want 01", pc_o);
        end
        zero_i = 1'b1;
        run4(16'h4009);
        zero_i = 1'b0;
        vectors++;
        if (pc_o !== 5'd9) begin
            miscompares++;
            $display("FAIL brz_taken: got pc=%h want 09", pc_o);
        end
        instr_i = 16'h5003;
        step();
        step();
        carry_i = 1'b1;
        step();
        carry_i = 1'b0;
        step();
        vectors++;
        if (pc_o !== 5'd3) begin
            miscompares++;
            $display("FAIL brc_exec_sample: got pc=%h want 03", pc_o);
        end
        run4(16'h5003);
        vectors++;
        if (pc_o !== 5'd4) begin
            miscompares++;
            $display("FAIL brc_not_taken: got pc=%h want 04", pc_o);
        end
        run4(16'h10FF);
        vectors++;
        if (pc_o !== 5'd31) begin
            miscompares++;
            $display("FAIL jmp_trunc: got pc=%h want 1f", pc_o);
        end
        run4(16'h0000);
        vectors++;
        if (pc_o !== 5'd0) begin
            miscompares++;
            $display("FAIL pc_wrap: got pc=%h want 00", pc_o);
        end
    endtask

    task automatic test_stall_freeze();
        apply_reset();
        instr_i = 16'h7105; instr_valid_i = 1'b1; exec_done_i = 1'b0;
        step();
        step();
        vectors++;
        if ({state_o, alu_ce_o} !== {3'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_enter: got st=%0d alu=%b want 2/1", state_o, alu_ce_o);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({state_o, alu_ce_o, rf_we_o} !== {3'd2, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got st=%0d alu=%b rf=%b want 2/1/0", i, state_o, alu_ce_o, rf_we_o);
            end
        end
        exec_done_i = 1'b1;
        step();
        vectors++;
        if ({state_o, alu_ce_o, acc_we_o, rf_we_o, dm_we_o} !== {3'd3, 4'b0010}) begin
            miscompares++;
            $display("FAIL stall_wb: got st=%0d strobes=%b want 3/0010", state_o,
                     {alu_ce_o, acc_we_o, rf_we_o, dm_we_o});
        end
        step();
        vectors++;
        if ({state_o, pc_o, rf_we_o} !== {3'd0, 5'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_done: got st=%0d pc=%h rf=%b want 0/01/0", state_o, pc_o, rf_we_o);
        end
        exec_done_i = 1'b0; instr_i = 16'h7205;
        step();
        step();
        en = 1'b0;
        step();
        vectors++;
        if ({state_o, alu_ce_o, dm_we_o, pc_o, ir_o} !== {3'd2, 2'b00, 5'd1, 16'h7205}) begin
            miscompares++;
            $display("FAIL freeze: got st=%0d alu=%b dm=%b pc=%h ir=%h want 2/0/0/01/7205",
                     state_o, alu_ce_o, dm_we_o, pc_o, ir_o);
        end
        exec_done_i = 1'b1;
        step();
        step();
        vectors++;
        if ({state_o, alu_ce_o, acc_we_o, rf_we_o, dm_we_o} !== {3'd2, 4'b0000}) begin
            miscompares++;
            $display("FAIL freeze_done_ignored: got st=%0d strobes=%b want 2/0000", state_o,
                     {alu_ce_o, acc_we_o, rf_we_o, dm_we_o});
        end
        en = 1'b1;
        step();
        vectors++;
        if ({state_o, dm_we_o} !== {3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL resume_wb: got st=%0d dm=%b want 3/1", state_o, dm_we_o);
        end
        step();
        vectors++;
        if ({state_o, pc_o, dm_we_o} !== {3'd0, 5'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL resume_done: got st=%0d pc=%h dm=%b want 0/02/0", state_o, pc_o, dm_we_o);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        run4(16'h0000);
        instr_i = 16'h6000;
        step();
        step();
        vectors++;
        if ({state_o, halted_o, stack_err_o, pc_o} !== {3'd4, 2'b10, 5'd1}) begin
            miscompares++;
            $display("FAIL halt_enter: got st=%0d h=%b e=%b pc=%h want 4/1/0/01", state_o, halted_o, stack_err_o, pc_o);
        end
        instr_i = 16'h7005;
        repeat (4) step();
        vectors++;
        if ({state_o, alu_ce_o, acc_we_o, rf_we_o, dm_we_o, pc_o} !== {3'd4, 4'b0000, 5'd1}) begin
            miscompares++;
            $display("FAIL halt_sticky: got st=%0d strobes=%b pc=%h want 4/0000/01", state_o,
                     {alu_ce_o, acc_we_o, rf_we_o, dm_we_o}, pc_o);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        instr_i = 16'hF305; instr_valid_i = 1'b1; exec_done_i = 1'b1;
        repeat (3) step();
        vectors++;
        if ({state_o, alu_ce_o, acc_we_o, rf_we_o, dm_we_o} !== {3'd3, 4'b0000}) begin
            miscompares++;
            $display("FAIL mode3_wb: got st=%0d strobes=%b want 3/0000", state_o,
                     {alu_ce_o, acc_we_o, rf_we_o, dm_we_o});
        end
        step();
        run4(16'h8205);
        run4(16'h1007);
        vectors++;
        if ({pc_o, state_o} !== {5'd7, 3'd0}) begin
            miscompares++;
            $display("FAIL b2b_pc: got pc=%h st=%0d want 07/0", pc_o, state_o);
        end
    endtask

    task automatic test_reset_in_wb();
        apply_reset();
        run4(16'h0000);
        instr_i = 16'h7105; instr_valid_i = 1'b1; exec_done_i = 1'b1;
        repeat (3) step();
        vectors++;
        if ({state_o, rf_we_o, pc_o} !== {3'd3, 1'b1, 5'd1}) begin
            miscompares++;
            $display("FAIL rst_wb_pre: got st=%0d rf=%b pc=%h want 3/1/01", state_o, rf_we_o, pc_o);
        end
        rstn = 1'b0;
        #1;
        vectors++;
        if ({rf_we_o, pc_o, state_o} !== {1'b0, 5'd0, 3'd0}) begin
            miscompares++;
            $display("FAIL rst_wb_drop: got rf=%b pc=%h st=%0d want 0/00/0", rf_we_o, pc_o, state_o);
        end
        step();
        rstn = 1'b1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_dp_op();
        test_call_ret();
        test_stack_errors();
        test_branch();
        test_stall_freeze();
        test_halt();
        test_back_to_back();
        test_reset_in_wb();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/seq_ctrl_unit.md
SEQ_CTRL_UNIT -- requirements
Module: seq_ctrl_unit

Interface
REQ-001 SHALL have parameter PC_W, default 5: program counter width.
REQ-002 SHALL have parameter INSTR_W, default 16: instruction width, INSTR_W >= PC_W+8.
REQ-003 SHALL have parameter STACK_DEPTH, default 8: call-stack entries, >= 2.
REQ-004 SHALL have port clk, input, 1: clock, all state on rising edge.
REQ-005 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port en, input, 1: run enable; 0 freezes the sequencer (program-load mode).
REQ-007 SHALL have port instr_i, input, INSTR_W: instruction word; opcode [INSTR_W-1:INSTR_W-4], mode [INSTR_W-5:INSTR_W-8], operand [INSTR_W-9:0].
REQ-008 SHALL have port instr_valid_i, input, 1: instr_i valid for pc_o.
REQ-009 SHALL have port exec_done_i, input, 1: datapath finished current operation.
REQ-010 SHALL have ports zero_i and carry_i, input, 1 each: datapath flags.
REQ-011 SHALL have port pc_o, output, PC_W: program counter.
REQ-012 SHALL have port state_o, output, 3: FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4.
REQ-013 SHALL have ports alu_ce_o, acc_we_o, rf_we_o, dm_we_o, output, 1 each: datapath strobes.
REQ-014 SHALL have port ir_o, output, INSTR_W: latched instruction register.
REQ-015 SHALL have port sp_o, output, clog2(STACK_DEPTH+1): stack occupancy.
REQ-016 SHALL have ports halted_o and stack_err_o, output, 1 each.

Function
REQ-017 Opcodes SHALL be: 0 NOP, 1 JMP, 2 CALL, 3 RET, 4 BRZ, 5 BRC, 6 HALT, 7-15 datapath ops.
REQ-018 FETCH SHALL wait until instr_valid_i=1, then latch instr_i into ir_o and go to DECODE.
REQ-019 DECODE SHALL last 1 cycle; HALT opcode goes to HALT, all others to EXEC.
REQ-020 EXEC for opcodes 0-5 SHALL last 1 cycle; flags zero_i/carry_i sampled in this cycle.
REQ-021 EXEC for opcodes 7-15 SHALL hold alu_ce_o=1 and remain until exec_done_i=1 (minimum 1 cycle), then go to WB.
REQ-022 WB SHALL last 1 cycle and return to FETCH; for opcodes 7-15 pulse exactly one strobe by mode[1:0]: 0 acc_we_o, 1 rf_we_o, 2 dm_we_o, 3 none.
REQ-023 PC update in WB: JMP -> operand[PC_W-1:0]; CALL -> push pc_o+1, pc <= target; RET -> pop; BRZ/BRC taken -> target, else pc_o+1; all others pc_o+1.
REQ-024 PC increment SHALL wrap modulo 2^PC_W (max -> 0) with no flag.
REQ-025 CALL with sp_o=STACK_DEPTH SHALL not push, not change pc_o, set stack_err_o, enter HALT.
REQ-026 RET with sp_o=0 SHALL not change pc_o, set stack_err_o, enter HALT.
REQ-027 Minimum instruction latency SHALL be 4 cycles (instr_valid_i and exec_done_i held 1).
REQ-028 en=0 SHALL freeze state, pc, ir, stack; all strobes forced 0; resume where frozen when en=1.
REQ-029 HALT SHALL assert halted_o, keep all strobes 0, and be left only by reset.
REQ-030 Strobes SHALL be registered outputs; exec_done_i arriving in the WB cycle SHALL be ignored.

Reset
REQ-031 rstn low SHALL immediately force state FETCH, pc_o=0, ir_o=0, sp_o=0, all strobes 0, halted_o=0, stack_err_o=0.
REQ-032 Reset mid-EXEC or mid-WB SHALL drop any pending strobe in the same cycle; stack contents need not clear.

Verification
REQ-033 Datapath op 0x7005 (mode 0), valid/done held 1 from pc=0 -> state 0,1,2,3, acc_we_o pulsed 1 cycle in WB, pc_o=1 after 4 cycles.
REQ-034 CALL 0x2010 at pc=3 then RET at pc=0x10 -> sp_o 0->1->0, pc_o 0x10 then 4.
REQ-035 Nine nested CALLs with STACK_DEPTH=8 -> 9th sets stack_err_o=1, halted_o=1, pc_o unchanged, sp_o=8.
REQ-036 BRZ 0x4009 with zero_i=0 then zero_i=1 -> pc_o advances by 1, then loads 9; pc_o=31 with NOP -> wraps to 0.
REQ-037 exec_done_i low 5 cycles in EXEC -> alu_ce_o held 6 cycles, no write strobe until WB; en=0 during this -> full freeze, no strobes.
REQ-038 rstn asserted in WB of a rf_we op -> rf_we_o low immediately, pc_o=0, state_o=0.
